sync_fifo: RTL and testbench

Parametrised synchronous FIFO for the switch datapath. It replaces the fixed 64x8 port memory with configurable depth and width, and adds full/empty and almost-full/almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. A FWFT parameter selects standard mode (registered read, 1-cycle latency) or first-word-fall-through mode. Each switch input/output port instantiates one sync_fifo between the packet parser and the output arbiter.

---
 rtl/sync_fifo.sv | 120 ++++++++++++
 tb/tb_sync_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and sticky
// overflow/underflow errors. FWFT selects a registered read or a fall-through head word.
module sync_fifo #(
  parameter int DEPTH   = 64,
  parameter int W_WIDTH = 8,
  parameter int AF_LVL  = DEPTH - 4,
  parameter int AE_LVL  = 4,
  parameter bit FWFT    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W_WIDTH-1:0]       wr_data,
  input  logic                     rd_en,
  output logic [W_WIDTH-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LVL);

  logic [W_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Every status flag comes from the registered count, never from pointer comparison.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = empty ? '0 : mem[rd_ptr_q];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [W_WIDTH-1:0] rd_data_q, rd_data_d;
      logic               rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a DEPTH=8 standard-mode instance checked against a queue
// scoreboard and reference counters, plus a DEPTH=8 FWFT instance.
`timescale 1ns/1ps
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, clr_err;
  logic       wr_en0, rd_en0, rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [7:0] wr_data0, rd_data0;
  logic [3:0] count0;
  logic       wr_en1, rd_en1, rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [7:0] wr_data1, rd_data1;
  logic [3:0] count1;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [3:0] m_count;
  logic       m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(8), .W_WIDTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0),
    .underflow(udf0), .clr_err(clr_err));

  sync_fifo #(.DEPTH(8), .W_WIDTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1),
    .underflow(udf1), .clr_err(clr_err));

  // One clock of stimulus on dut0; updates the reference model and compares all outputs.
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic ce, input logic r);
    logic       wacc, racc;
    logic [7:0] exp;
    wr_en0 = we; wr_data0 = wd; rd_en0 = re; clr_err = ce; rst = r;
    wacc = we && (m_count != 4'd8);
    racc = re && (m_count != 4'd0);
    @(posedge clk); #1;
    if (r) begin
      m_count = 4'd0; m_ovf = 1'b0; m_udf = 1'b0; racc = 1'b0;
      exp_q.delete();
    end else begin
      m_ovf = (m_ovf && !ce) || (we && m_count == 4'd8);
      m_udf = (m_udf && !ce) || (re && m_count == 4'd0);
      if (wacc) exp_q.push_back(wd);
      if (wacc && !racc) m_count = m_count + 4'd1;
      else if (!wacc && racc) m_count = m_count - 4'd1;
    end
    checks++;
    if (rd_valid0 !== racc) begin
      failures++; $display("FAIL rd_valid: got %b expected %b", rd_valid0, racc);
    end
    if (rd_valid0 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL scoreboard: rd_valid with no expected word, got %02h", rd_data0);
      end else begin
        exp = exp_q.pop_front();
        if (rd_data0 !== exp) begin
          failures++; $display("FAIL rd_data: got %02h expected %02h", rd_data0, exp);
        end
      end
    end
    checks += 7;
    if (count0 !== m_count) begin failures++; $display("FAIL count: got %0d expected %0d", count0, m_count); end
    if (full0 !== (m_count == 4'd8)) begin failures++; $display("FAIL full: got %b count %0d", full0, m_count); end
    if (empty0 !== (m_count == 4'd0)) begin failures++; $display("FAIL empty: got %b count %0d", empty0, m_count); end
    if (af0 !== (m_count >= 4'd6)) begin failures++; $display("FAIL almost_full: got %b count %0d", af0, m_count); end
    if (ae0 !== (m_count <= 4'd2)) begin failures++; $display("FAIL almost_empty: got %b count %0d", ae0, m_count); end
    if (ovf0 !== m_ovf) begin failures++; $display("FAIL overflow: got %b expected %b", ovf0, m_ovf); end
    if (udf0 !== m_udf) begin failures++; $display("FAIL underflow: got %b expected %b", udf0, m_udf); end
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (rd_data0 !== 8'h00) begin failures++; $display("FAIL reset rd_data: got %02h expected 00", rd_data0); end
    if (rd_valid1 !== 1'b0) begin failures++; $display("FAIL reset fwft rd_valid: got %b expected 0", rd_valid1); end
    if (count1 !== 4'd0) begin failures++; $display("FAIL reset fwft count: got %0d expected 0", count1); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks += 2;
      if (af0 !== (i >= 6)) begin failures++; $display("FAIL fill almost_full at %0d: got %b", i, af0); end
      if (full0 !== (i == 8)) begin failures++; $display("FAIL fill full at %0d: got %b", i, full0); end
    end
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (ovf0 !== 1'b1) begin failures++; $display("FAIL ninth write overflow: got %b expected 1", ovf0); end
    if (count0 !== 4'd8) begin failures++; $display("FAIL ninth write count: got %0d expected 8", count0); end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (rd_data0 !== 8'(i)) begin failures++; $display("FAIL drain data: got %02h expected %02h", rd_data0, 8'(i)); end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (empty0 !== 1'b1) begin failures++; $display("FAIL drain empty: got %b expected 1", empty0); end
    if (udf0 !== 1'b1) begin failures++; $display("FAIL extra read underflow: got %b expected 1", udf0); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 8'(5 * r + k), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_data0 !== 8'(5 * r + k)) begin
          failures++; $display("FAIL wrap data: got %02h expected %02h", rd_data0, 8'(5 * r + k));
        end
      end
    end
    checks++;
    if (count0 !== 4'd0) begin failures++; $display("FAIL wrap final count: got %0d expected 0", count0); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (count0 !== 4'd3) begin failures++; $display("FAIL simul count: got %0d expected 3", count0); end
    end
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (count0 !== 4'd7) begin failures++; $display("FAIL full rd+wr count: got %0d expected 7", count0); end
    if (ovf0 !== 1'b1) begin failures++; $display("FAIL full rd+wr overflow: got %b expected 1", ovf0); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (count0 !== 4'd1) begin failures++; $display("FAIL empty rd+wr count: got %0d expected 1", count0); end
    if (udf0 !== 1'b1) begin failures++; $display("FAIL empty rd+wr underflow: got %b expected 1", udf0); end
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_errors_and_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf0 !== 1'b0) begin failures++; $display("FAIL clr_err overflow: got %b expected 0", ovf0); end
    step(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf0 !== 1'b1) begin failures++; $display("FAIL set beats clr_err: got %b expected 1", ovf0); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    checks += 2;
    if (count0 !== 4'd0) begin failures++; $display("FAIL mid-stream reset count: got %0d expected 0", count0); end
    if (empty0 !== 1'b1) begin failures++; $display("FAIL mid-stream reset empty: got %b expected 1", empty0); end
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (rd_data0 !== 8'(8'hC0 + i)) begin
        failures++; $display("FAIL post-reset data: got %02h expected %02h", rd_data0, 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_fwft();
    wr_en0 = 1'b0; rd_en0 = 1'b0; clr_err = 1'b0; rst = 1'b0;
    wr_en1 = 1'b1; wr_data1 = 8'hA5;
    @(posedge clk); #1;
    wr_en1 = 1'b0;
    checks += 2;
    if (rd_valid1 !== 1'b1) begin failures++; $display("FAIL fwft valid after write: got %b expected 1", rd_valid1); end
    if (rd_data1 !== 8'hA5) begin failures++; $display("FAIL fwft head: got %02h expected a5", rd_data1); end
    @(posedge clk); #1;
    checks++;
    if (rd_data1 !== 8'hA5) begin failures++; $display("FAIL fwft head held: got %02h expected a5", rd_data1); end
    rd_en1 = 1'b1;
    @(posedge clk); #1;
    rd_en1 = 1'b0;
    checks += 2;
    if (empty1 !== 1'b1) begin failures++; $display("FAIL fwft pop empty: got %b expected 1", empty1); end
    if (rd_valid1 !== 1'b0) begin failures++; $display("FAIL fwft pop valid: got %b expected 0", rd_valid1); end
    wr_en1 = 1'b1; wr_data1 = 8'hB1;
    @(posedge clk); #1;
    wr_data1 = 8'hB2;
    @(posedge clk); #1;
    wr_en1 = 1'b0; rd_en1 = 1'b1;
    checks++;
    if (rd_data1 !== 8'hB1) begin failures++; $display("FAIL fwft first of two: got %02h expected b1", rd_data1); end
    @(posedge clk); #1;
    rd_en1 = 1'b0;
    checks += 2;
    if (rd_data1 !== 8'hB2) begin failures++; $display("FAIL fwft next word: got %02h expected b2", rd_data1); end
    if (count1 !== 4'd1) begin failures++; $display("FAIL fwft count: got %0d expected 1", count1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; wr_data0 = 8'h00;
    wr_en1 = 1'b0; rd_en1 = 1'b0; wr_data1 = 8'h00;
    m_count = 4'd0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors_and_reset();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
